// File: rtl/mdu_dispatch_pkg.sv
// mdu_dispatch_pkg
// Shared encodings for the EX-stage MDU initiator. The decoder, the MDU and
// mdu_dispatch all use these types:
//   md_op_e     - MDU instruction class carried in EX (ex_op)
//   mdu_ctrl_e  - control code presented to the MDU (MDUCtrl)
//   mdu_state_e - latency-checker FSM state
package mdu_dispatch_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_e;

  // Code 0 means "no operation"; it is what mdu_ctrl shows when nothing issues.
  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6
  } mdu_ctrl_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUED = 2'd1,
    RUN    = 2'd2
  } mdu_state_e;

  // Unused encodings 9-15 behave as MD_NONE.
  function automatic md_op_e decode_op(input logic [3:0] op);
    return (op > 4'd8) ? MD_NONE : md_op_e'(op);
  endfunction

  function automatic logic is_muldiv(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic mdu_ctrl_e to_mdu_ctrl(input md_op_e op);
    case (op)
      MD_MULT:  return MDU_MULT;
      MD_MULTU: return MDU_MULTU;
      MD_DIV:   return MDU_DIV;
      MD_DIVU:  return MDU_DIVU;
      MD_MTHI:  return MDU_MTHI;
      MD_MTLO:  return MDU_MTLO;
      default:  return MDU_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mdu_dispatch_latency_checker.sv
// mdu_latency_checker
// Shadow model of MDU latency. Tracks each mult/div issue through
// IDLE -> ISSUED -> RUN and flags any deviation of mdu_busy from the expected
// busy window.
// Ports:
//   clk, reset     - clock, asynchronous active-low reset
//   issue_muldiv   - a mult/multu/div/divu is issued this cycle
//   issue_div      - the issued op is a divide (selects DIV_LAT)
//   mdu_busy       - Busy from the MDU
//   state          - current FSM state
//   protocol_err   - sticky latency-violation flag
module mdu_latency_checker
  import mdu_dispatch_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       issue_muldiv,
  input  logic       issue_div,
  input  logic       mdu_busy,
  output mdu_state_e state,
  output logic       protocol_err
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  mdu_state_e       state_d;
  logic [CNT_W-1:0] exp_cnt, exp_cnt_d;
  logic [CNT_W-1:0] load_val;
  logic             err_set;

  assign load_val = issue_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      exp_cnt      <= '0;
      protocol_err <= 1'b0;
    end else begin
      state        <= state_d;
      exp_cnt      <= exp_cnt_d;
      protocol_err <= protocol_err | err_set;
    end
  end

  // Next-state logic. A mult/div may issue in the cycle RUN exits because
  // stall is already low then; it goes straight back to ISSUED.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d = state;
    case (state)
      IDLE:    if (issue_muldiv) state_d = ISSUED;
      ISSUED:  state_d = RUN;
      RUN:     if (!mdu_busy) state_d = issue_muldiv ? ISSUED : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Expected-latency counter and violation detection.
  // exp_cnt is loaded with the full latency; ISSUED does not count, so a
  // well-behaved MDU drops busy in RUN exactly when exp_cnt has reached 1.
  always_comb begin
    exp_cnt_d = exp_cnt;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        if (issue_muldiv) exp_cnt_d = load_val;
      end
      ISSUED: begin
        if (!mdu_busy) err_set = 1'b1;
      end
      RUN: begin
        if (mdu_busy) begin
          if (exp_cnt == '0) err_set = 1'b1;
          else               exp_cnt_d = exp_cnt - CNT_W'(1);
        end else begin
          if (exp_cnt != CNT_W'(1)) err_set = 1'b1;
          exp_cnt_d = issue_muldiv ? load_val : '0;
        end
      end
      default: exp_cnt_d = '0;
    endcase
  end

endmodule

// File: rtl/mdu_dispatch.sv
// mdu_dispatch
// EX-stage initiator for the multiply/divide unit. Decodes the EX MDU class,
// issues Start/MDUCtrl/operands with zero latency, stalls the front of the
// pipeline while an MDU operation is outstanding, and returns HI/LO for
// mfhi/mflo.
// Ports:
//   clk, reset              - clock, asynchronous active-low reset
//   ex_valid, ex_op, flush  - EX instruction qualifier, MDU class, squash
//   ex_rs, ex_rt            - forwarded operands
//   stall_out               - freeze PC/IF/ID/EX this cycle
//   mdu_start, mdu_ctrl     - MDU Start / MDUCtrl
//   mdu_srca, mdu_srcb      - MDU SrcA / SrcB
//   mdu_busy, mdu_hi, mdu_lo- MDU Busy and result registers
//   rd_valid, rd_data       - mfhi/mflo result for EX
//   protocol_err            - sticky MDU latency violation
//   stall_cnt               - saturating count of MDU stall cycles
module mdu_dispatch
  import mdu_dispatch_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [3:0]  ex_op,
  input  logic [31:0] ex_rs,
  input  logic [31:0] ex_rt,
  input  logic        flush,
  output logic        stall_out,
  output logic        mdu_start,
  output logic [2:0]  mdu_ctrl,
  output logic [31:0] mdu_srca,
  output logic [31:0] mdu_srcb,
  input  logic        mdu_busy,
  input  logic [31:0] mdu_hi,
  input  logic [31:0] mdu_lo,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        protocol_err,
  output logic [31:0] stall_cnt
);

  md_op_e     op;
  mdu_state_e state;
  logic       live;
  logic       issue;
  logic       read;

  assign op   = decode_op(ex_op);
  assign live = ex_valid & ~flush & (op != MD_NONE);

  // ISSUED covers the cycle in which the MDU has just sampled Start, so a
  // dependent op never slips through before Busy is observed.
  assign stall_out = live & (mdu_busy | (state == ISSUED));

  assign issue = live & ~stall_out & (op inside {[MD_MULT:MD_MTLO]});
  assign read  = live & ~stall_out & ((op == MD_MFHI) || (op == MD_MFLO));

  always_comb begin
    mdu_start = 1'b0;
    mdu_ctrl  = MDU_NONE;
    mdu_srca  = '0;
    mdu_srcb  = '0;
    if (issue) begin
      mdu_start = 1'b1;
      mdu_ctrl  = to_mdu_ctrl(op);
      mdu_srca  = ex_rs;
      mdu_srcb  = ex_rt;
    end
  end

  always_comb begin
    rd_valid = read;
    rd_data  = '0;
    if (read) rd_data = (op == MD_MFHI) ? mdu_hi : mdu_lo;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (stall_out && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  mdu_latency_checker #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_checker (
    .clk          (clk),
    .reset        (reset),
    .issue_muldiv (issue & is_muldiv(op)),
    .issue_div    (is_div(op)),
    .mdu_busy     (mdu_busy),
    .state        (state),
    .protocol_err (protocol_err)
  );

endmodule

// File: tb/tb_mdu_dispatch.sv
module tb_mdu_dispatch;
  import mdu_dispatch_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [3:0]  ex_op;
  logic [31:0] ex_rs, ex_rt;
  logic        flush;
  logic        stall_out, mdu_start;
  logic [2:0]  mdu_ctrl;
  logic [31:0] mdu_srca, mdu_srcb;
  logic        mdu_busy;
  logic [31:0] mdu_hi, mdu_lo;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        protocol_err;
  logic [31:0] stall_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mdu_dispatch #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk          (clk),
    .reset        (reset),
    .ex_valid     (ex_valid),
    .ex_op        (ex_op),
    .ex_rs        (ex_rs),
    .ex_rt        (ex_rt),
    .flush        (flush),
    .stall_out    (stall_out),
    .mdu_start    (mdu_start),
    .mdu_ctrl     (mdu_ctrl),
    .mdu_srca     (mdu_srca),
    .mdu_srcb     (mdu_srcb),
    .mdu_busy     (mdu_busy),
    .mdu_hi       (mdu_hi),
    .mdu_lo       (mdu_lo),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .protocol_err (protocol_err),
    .stall_cnt    (stall_cnt)
  );

  // ---------------- behavioural MDU ----------------
  int          mult_lat_m = 5;
  int          div_lat_m  = 10;
  int          busy_cnt;

  function automatic logic [63:0] mdu_calc(input logic [2:0] c, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] h,
                                           input logic [31:0] l);
    longint          sa, sb;
    longint unsigned ua, ub;
    int              ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = a;
    ib = b;
    case (c)
      3'd1:    return sa * sb;
      3'd2:    return ua * ub;
      3'd3:    return {32'(ia % ib), 32'(ia / ib)};
      3'd4:    return {a % b, a / b};
      3'd5:    return {a, l};
      3'd6:    return {h, a};
      default: return {h, l};
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_cnt <= 0;
      mdu_hi   <= '0;
      mdu_lo   <= '0;
    end else if (mdu_start) begin
      {mdu_hi, mdu_lo} <= mdu_calc(mdu_ctrl, mdu_srca, mdu_srcb, mdu_hi, mdu_lo);
      if (mdu_ctrl == 3'd1 || mdu_ctrl == 3'd2)      busy_cnt <= mult_lat_m;
      else if (mdu_ctrl == 3'd3 || mdu_ctrl == 3'd4) busy_cnt <= div_lat_m;
      else                                           busy_cnt <= 0;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  assign mdu_busy = (busy_cnt != 0);

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] rs,
                       input logic [31:0] rt, input logic fl);
    ex_valid = v;
    ex_op    = op;
    ex_rs    = rs;
    ex_rt    = rt;
    flush    = fl;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Holds the current EX inputs until rd_valid appears (bounded). Returns at
  // the negedge of the read cycle with the number of stalled cycles seen.
  task automatic run_until_read(output int stalls);
    stalls = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rd_valid) return;
      if (stall_out) stalls++;
      adv();
    end
    @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        v;
    logic [3:0]  op;
    logic [31:0] rs, rt;
    logic        fl;
    logic        e_stall, e_start;
    logic [2:0]  e_ctrl;
    logic [31:0] e_a, e_b;
    logic        e_rdv;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(input logic v, input logic [3:0] op, input logic [31:0] rs,
                              input logic [31:0] rt, input logic fl, input logic e_stall,
                              input logic e_start, input logic [2:0] e_ctrl,
                              input logic [31:0] e_a, input logic [31:0] e_b,
                              input logic e_rdv, input logic [31:0] e_rd);
    vec_t t;
    t = '{v, op, rs, rt, fl, e_stall, e_start, e_ctrl, e_a, e_b, e_rdv, e_rd};
    return t;
  endfunction

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;

    // mult 7 x -3, mfhi held through 5 stall cycles, then mflo
    vecs[0] = mk(1, 4'd1, 32'd7, 32'hFFFF_FFFD, 0, 0, 1, 3'd1, 32'd7, 32'hFFFF_FFFD, 0, 0);
    for (int i = 1; i <= 5; i++) vecs[i] = mk(1, 4'd7, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    vecs[6] = mk(1, 4'd7, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF);
    vecs[7] = mk(1, 4'd8, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFEB);
    // mtlo / mthi followed immediately by a read: no stall, new value
    vecs[8]  = mk(1, 4'd6, 32'h1234, 0, 0, 0, 1, 3'd6, 32'h1234, 0, 0, 0);
    vecs[9]  = mk(1, 4'd8, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1234);
    vecs[10] = mk(1, 4'd5, 32'hCAFE, 32'h55, 0, 0, 1, 3'd5, 32'hCAFE, 32'h55, 0, 0);
    vecs[11] = mk(1, 4'd7, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFE);
    // unused encodings, invalid EX, flushed EX: all outputs quiet
    vecs[12] = mk(1, 4'd9,  32'd1, 32'd2, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[13] = mk(1, 4'd15, 32'd1, 32'd2, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[14] = mk(0, 4'd1,  32'd5, 32'd6, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[15] = mk(1, 4'd1,  32'd5, 32'd6, 1, 0, 0, 0, 0, 0, 0, 0);
    // multu 3 x 5, bubbles (not live: no stall), then reads
    vecs[16] = mk(1, 4'd2, 32'd3, 32'd5, 0, 0, 1, 3'd2, 32'd3, 32'd5, 0, 0);
    for (int i = 17; i <= 21; i++) vecs[i] = mk(0, 4'd7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[22] = mk(1, 4'd8, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'd15);
    vecs[23] = mk(1, 4'd7, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'd0);

    // reset
    reset = 1'b0;
    drive(0, 4'd0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_stall_cnt", stall_cnt, 0);
    check("reset_protocol_err", {31'd0, protocol_err}, 0);
    check("reset_state", {30'd0, dut.u_checker.state}, {30'd0, IDLE});
    check("reset_start", {31'd0, mdu_start}, 0);
    reset = 1'b1;
    adv();

    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].v, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].fl);
      @(negedge clk);
      check($sformatf("v%0d_stall", i), {31'd0, stall_out}, {31'd0, vecs[i].e_stall});
      check($sformatf("v%0d_start", i), {31'd0, mdu_start}, {31'd0, vecs[i].e_start});
      check($sformatf("v%0d_ctrl", i), {29'd0, mdu_ctrl}, {29'd0, vecs[i].e_ctrl});
      check($sformatf("v%0d_srca", i), mdu_srca, vecs[i].e_a);
      check($sformatf("v%0d_srcb", i), mdu_srcb, vecs[i].e_b);
      check($sformatf("v%0d_rd_valid", i), {31'd0, rd_valid}, {31'd0, vecs[i].e_rdv});
      check($sformatf("v%0d_rd_data", i), rd_data, vecs[i].e_rd);
      adv();
    end
    drive(0, 4'd0, 0, 0, 0);
    @(negedge clk);
    check("table_stall_cnt", stall_cnt, 32'd5);
    check("table_protocol_err", {31'd0, protocol_err}, 0);
    adv();

    // divu 100/7 then immediate mflo: 10 stalls, quotient 14
    drive(1, 4'd4, 32'd100, 32'd7, 0);
    @(negedge clk);
    check("divu_start", {31'd0, mdu_start}, 1);
    check("divu_ctrl", {29'd0, mdu_ctrl}, 32'd4);
    adv();
    drive(1, 4'd8, 0, 0, 0);
    run_until_read(n);
    check("divu_stalls", n, 10);
    check("divu_rd_valid", {31'd0, rd_valid}, 1);
    check("divu_rd_data", rd_data, 32'd14);
    adv();
    drive(0, 4'd0, 0, 0, 0);
    @(negedge clk);
    check("divu_protocol_err", {31'd0, protocol_err}, 0);
    check("divu_stall_cnt", stall_cnt, 32'd15);
    adv();

    // div -20/3, flushed mfhi at cycle 3, live mfhi from cycle 4
    drive(1, 4'd3, 32'hFFFF_FFEC, 32'd3, 0);
    @(negedge clk);
    check("div_start", {31'd0, mdu_start}, 1);
    adv();
    drive(0, 4'd0, 0, 0, 0);
    adv();
    adv();
    drive(1, 4'd7, 0, 0, 1);
    @(negedge clk);
    check("flush_stall", {31'd0, stall_out}, 0);
    check("flush_rd_valid", {31'd0, rd_valid}, 0);
    check("flush_start", {31'd0, mdu_start}, 0);
    check("flush_state", {30'd0, dut.u_checker.state}, {30'd0, RUN});
    adv();
    drive(1, 4'd7, 0, 0, 0);
    run_until_read(n);
    check("flush_post_stalls", n, 7);
    check("div_rd_hi", rd_data, 32'hFFFF_FFFE);
    check("div_exit_state", {30'd0, dut.u_checker.state}, {30'd0, RUN});
    adv();
    drive(0, 4'd0, 0, 0, 0);
    @(negedge clk);
    check("div_idle_state", {30'd0, dut.u_checker.state}, {30'd0, IDLE});
    check("flush_stall_cnt", stall_cnt, 32'd22);
    adv();

    // div 9/2 with a mult waiting in EX: mult issues as RUN exits
    drive(1, 4'd3, 32'd9, 32'd2, 0);
    adv();
    drive(1, 4'd1, 32'd2, 32'd3, 0);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (mdu_start) break;
      if (stall_out) n++;
      adv();
    end
    check("b2b_stalls", n, 10);
    check("b2b_start", {31'd0, mdu_start}, 1);
    check("b2b_ctrl", {29'd0, mdu_ctrl}, 32'd1);
    check("b2b_srca", mdu_srca, 32'd2);
    check("b2b_run_state", {30'd0, dut.u_checker.state}, {30'd0, RUN});
    adv();
    check("b2b_issued_state", {30'd0, dut.u_checker.state}, {30'd0, ISSUED});
    drive(1, 4'd8, 0, 0, 0);
    run_until_read(n);
    check("b2b_mflo_stalls", n, 5);
    check("b2b_rd_lo", rd_data, 32'd6);
    adv();
    drive(0, 4'd0, 0, 0, 0);
    @(negedge clk);
    check("b2b_protocol_err", {31'd0, protocol_err}, 0);
    check("b2b_stall_cnt", stall_cnt, 32'd37);
    adv();

    // MDU model drops busy one cycle early after a mult
    mult_lat_m = 4;
    drive(1, 4'd1, 32'd1, 32'd1, 0);
    adv();
    drive(0, 4'd0, 0, 0, 0);
    repeat (8) adv();
    check("short_busy_err", {31'd0, protocol_err}, 1);
    mult_lat_m = 5;
    drive(1, 4'd1, 32'd1, 32'd1, 0);
    adv();
    drive(0, 4'd0, 0, 0, 0);
    repeat (8) adv();
    check("err_sticky", {31'd0, protocol_err}, 1);

    // reset asserted mid-RUN, away from any clock edge
    drive(1, 4'd3, 32'd50, 32'd5, 0);
    adv();
    drive(1, 4'd7, 0, 0, 0);
    repeat (3) adv();
    check("pre_reset_state", {30'd0, dut.u_checker.state}, {30'd0, RUN});
    check("pre_reset_stall_cnt", stall_cnt, 32'd40);
    #2;
    reset = 1'b0;
    #1;
    check("async_err_clr", {31'd0, protocol_err}, 0);
    check("async_state", {30'd0, dut.u_checker.state}, {30'd0, IDLE});
    check("async_stall_cnt", stall_cnt, 0);
    drive(0, 4'd0, 0, 0, 0);
    #1;
    check("reset_quiet_start", {31'd0, mdu_start}, 0);
    check("reset_quiet_stall", {31'd0, stall_out}, 0);
    check("reset_quiet_rd", rd_data, 0);
    @(negedge clk);
    reset = 1'b1;
    adv();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
